dmem_region_router: RTL and testbench

//  Data-memory bus router between the core's load/store port, one local memory (LMB) and NUM_PER peripheral slaves.

---
 rtl/dmem_region_router.sv | 218 +++++++++++++++++++++
 tb/tb_dmem_region_router.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_region_router.sv
// Data-memory router: core load/store port to one LMB and NUM_PER peripherals,
// with read-modify-write for partial LMB stores. Optional DMEM_BUS_ERR_EN adds bus_err_o.
module dmem_region_router #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_PER    = 2,
  parameter logic [DATA_WIDTH-1:0] LMB_LIMIT = DATA_WIDTH'('h47FFF),
  parameter logic [NUM_PER*DATA_WIDTH-1:0] PER_BASE =
    {DATA_WIDTH'(64'h4000_0000), DATA_WIDTH'(64'h0008_0000)},
  parameter logic [DATA_WIDTH-1:0] PER_SPAN  = DATA_WIDTH'('h1000)
) (
  input  logic                          clk,
  input  logic                          rst,
`ifdef DMEM_BUS_ERR_EN
  output logic                          bus_err_o,
`endif
  input  logic                          req_wr_en,
  input  logic                          req_rd_en,
  input  logic [DATA_WIDTH/8-1:0]       req_strobe,
  input  logic [DATA_WIDTH-1:0]         req_addr,
  input  logic [DATA_WIDTH-1:0]         req_wdata,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic                          stall_o,
  output logic                          misalign_o,
  output logic                          lmb_wr_en,
  output logic                          lmb_rd_en,
  output logic [DATA_WIDTH/8-1:0]       lmb_strobe,
  output logic [DATA_WIDTH-1:0]         lmb_addr,
  output logic [DATA_WIDTH-1:0]         lmb_wdata,
  input  logic [DATA_WIDTH-1:0]         lmb_rdata,
  output logic [NUM_PER-1:0]            per_wr_en,
  output logic [NUM_PER-1:0]            per_rd_en,
  output logic [NUM_PER*DATA_WIDTH/8-1:0] per_strobe,
  output logic [NUM_PER*DATA_WIDTH-1:0] per_addr,
  output logic [NUM_PER*DATA_WIDTH-1:0] per_wdata,
  input  logic [NUM_PER*DATA_WIDTH-1:0] per_rdata
);

  localparam int unsigned SB = DATA_WIDTH / 8;
  localparam int unsigned OB = $clog2(SB);
  localparam int unsigned SW = $clog2(SB + 1);

  typedef enum logic {IDLE, MERGE} state_t;
  state_t state, state_n;

  logic                  is_wr, is_rd;
  logic                  lmb_hit, mapped;
  logic [NUM_PER-1:0]    per_sel;
  logic [OB-1:0]         off;
  logic [SW-1:0]         size;
  logic                  full, misaligned;
  logic                  lmb_direct, lmb_partial, lmb_drop;
  logic [DATA_WIDTH-1:0] word_addr;

  logic [SB-1:0]         st_strobe;
  logic [OB-1:0]         st_off;
  logic [DATA_WIDTH-1:0] st_data;
  logic [DATA_WIDTH-1:0] st_addr;

  logic [SB-1:0]         merge_mask;
  logic [DATA_WIDTH-1:0] merge_data;
  logic [DATA_WIDTH-1:0] merged;

  logic                  ret_lmb;
  logic [NUM_PER-1:0]    ret_per;
  logic                  misalign_q;
`ifdef DMEM_BUS_ERR_EN
  logic                  bus_err_q;
`endif

  // Address decode and store classification
  always_comb begin
    is_wr   = req_wr_en;
    is_rd   = req_rd_en & ~req_wr_en;
    lmb_hit = (req_addr <= LMB_LIMIT);
    mapped  = lmb_hit;
    per_sel = '0;
    for (int unsigned i = 0; i < NUM_PER; i++) begin
      if (!mapped && (req_addr >= PER_BASE[i*DATA_WIDTH +: DATA_WIDTH]) &&
          ((req_addr - PER_BASE[i*DATA_WIDTH +: DATA_WIDTH]) < PER_SPAN)) begin
        per_sel[i] = 1'b1;
        mapped     = 1'b1;
      end
    end

    off               = req_addr[OB-1:0];
    word_addr         = req_addr;
    word_addr[OB-1:0] = '0;

    size = '0;
    for (int unsigned b = 0; b < SB; b++) begin
      size = size + SW'(req_strobe[b]);
    end

    full = (req_strobe == '1) && (off == '0);
    if (size == '0) begin
      misaligned = 1'b1;
    end else begin
      misaligned = ((SW'(off) % size) != '0);
    end

    lmb_direct  = is_wr && lmb_hit && full;
    lmb_partial = is_wr && lmb_hit && !full && !misaligned;
    lmb_drop    = is_wr && lmb_hit && !full && misaligned;
  end

  // Byte-merge of the latched store into the word read back from the LMB
  always_comb begin
    merge_mask = st_strobe << st_off;
    merge_data = st_data << {st_off, 3'b000};
    merged     = '0;
    for (int unsigned b = 0; b < SB; b++) begin
      merged[8*b +: 8] = merge_mask[b] ? merge_data[8*b +: 8] : lmb_rdata[8*b +: 8];
    end
  end

  always_comb begin
    state_n    = state;
    stall_o    = 1'b0;
    lmb_wr_en  = 1'b0;
    lmb_rd_en  = 1'b0;
    lmb_strobe = '0;
    lmb_addr   = '0;
    lmb_wdata  = '0;
    per_wr_en  = '0;
    per_rd_en  = '0;
    per_strobe = '0;
    per_addr   = '0;
    per_wdata  = '0;

    case (state)
      IDLE: begin
        if (lmb_direct) begin
          lmb_wr_en  = 1'b1;
          lmb_strobe = '1;
          lmb_addr   = word_addr;
          lmb_wdata  = req_wdata;
        end else if (lmb_partial) begin
          lmb_rd_en = 1'b1;
          lmb_addr  = word_addr;
          stall_o   = 1'b1;
          state_n   = MERGE;
        end else if (is_rd && lmb_hit) begin
          lmb_rd_en = 1'b1;
          lmb_addr  = word_addr;
        end

        for (int unsigned i = 0; i < NUM_PER; i++) begin
          if (per_sel[i] && (is_wr || is_rd)) begin
            per_wr_en[i]                           = is_wr;
            per_rd_en[i]                           = is_rd;
            per_strobe[i*SB +: SB]                 = req_strobe;
            per_addr[i*DATA_WIDTH +: DATA_WIDTH]   = req_addr;
            per_wdata[i*DATA_WIDTH +: DATA_WIDTH]  = req_wdata;
          end
        end
      end

      MERGE: begin
        // The stalled store is still on the request port; it is not re-decoded here.
        lmb_wr_en  = 1'b1;
        lmb_strobe = '1;
        lmb_addr   = st_addr;
        lmb_wdata  = merged;
        state_n    = IDLE;
      end

      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      st_strobe  <= '0;
      st_off     <= '0;
      st_data    <= '0;
      st_addr    <= '0;
      ret_lmb    <= 1'b0;
      ret_per    <= '0;
      misalign_q <= 1'b0;
`ifdef DMEM_BUS_ERR_EN
      bus_err_q  <= 1'b0;
`endif
    end else begin
      state <= state_n;
      if (state == IDLE && lmb_partial) begin
        st_strobe <= req_strobe;
        st_off    <= off;
        st_data   <= req_wdata;
        st_addr   <= word_addr;
      end
      ret_lmb    <= (state == IDLE) && is_rd && lmb_hit;
      ret_per    <= ((state == IDLE) && is_rd) ? per_sel : '0;
      misalign_q <= (state == IDLE) && lmb_drop;
`ifdef DMEM_BUS_ERR_EN
      bus_err_q  <= (state == IDLE) && (is_wr || is_rd) && !mapped;
`endif
    end
  end

  always_comb begin
    rsp_rdata = '0;
    if (ret_lmb) begin
      rsp_rdata = lmb_rdata;
    end
    for (int unsigned i = 0; i < NUM_PER; i++) begin
      if (ret_per[i]) begin
        rsp_rdata = rsp_rdata | per_rdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign misalign_o = misalign_q;
`ifdef DMEM_BUS_ERR_EN
  assign bus_err_o  = bus_err_q;
`endif

endmodule

// File: tb/tb_dmem_region_router.sv
// Directed bench for dmem_region_router: vector table for single-cycle accesses,
// hand sequences for read-modify-write, reset during merge and bus error.
module tb_dmem_region_router;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_wr_en = 1'b0, req_rd_en = 1'b0;
  logic [3:0]  req_strobe = '0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [31:0] rsp_rdata;
  logic        stall_o, misalign_o;
  logic        lmb_wr_en, lmb_rd_en;
  logic [3:0]  lmb_strobe;
  logic [31:0] lmb_addr, lmb_wdata;
  logic [31:0] lmb_rdata;
  logic [1:0]  per_wr_en, per_rd_en;
  logic [7:0]  per_strobe;
  logic [63:0] per_addr, per_wdata;
  logic [63:0] per_rdata = {32'hB0B1_B2B3, 32'hA0A1_A2A3};
`ifdef DMEM_BUS_ERR_EN
  logic        bus_err_o;
`endif

  int checks = 0;
  int errors = 0;

  dmem_region_router #(.DATA_WIDTH(32), .NUM_PER(2)) dut (
    .clk(clk), .rst(rst),
`ifdef DMEM_BUS_ERR_EN
    .bus_err_o(bus_err_o),
`endif
    .req_wr_en(req_wr_en), .req_rd_en(req_rd_en), .req_strobe(req_strobe),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_rdata(rsp_rdata),
    .stall_o(stall_o), .misalign_o(misalign_o),
    .lmb_wr_en(lmb_wr_en), .lmb_rd_en(lmb_rd_en), .lmb_strobe(lmb_strobe),
    .lmb_addr(lmb_addr), .lmb_wdata(lmb_wdata), .lmb_rdata(lmb_rdata),
    .per_wr_en(per_wr_en), .per_rd_en(per_rd_en), .per_strobe(per_strobe),
    .per_addr(per_addr), .per_wdata(per_wdata), .per_rdata(per_rdata)
  );

  always #5 clk = ~clk;

  // LMB slave: byte-strobed write, registered read
  logic [31:0] mem [0:1023];
  always @(posedge clk) begin
    if (lmb_wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (lmb_strobe[b]) mem[lmb_addr[11:2]][8*b +: 8] <= lmb_wdata[8*b +: 8];
      end
    end
    if (lmb_rd_en) lmb_rdata <= mem[lmb_addr[11:2]];
  end

  typedef struct {
    logic [1:0]  op;       // {wr, rd}
    logic [3:0]  strb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  e_lmb;    // {lmb_wr_en, lmb_rd_en}
    logic [3:0]  e_lstrb;
    logic [31:0] e_laddr;
    logic [3:0]  e_per;    // {per_wr_en, per_rd_en}
    logic [63:0] e_paddr;
    logic [31:0] e_rsp;
    logic        e_mis;
  } vec_t;

  vec_t tbl [18];

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic wr, input logic rd, input logic [3:0] s,
                       input logic [31:0] a, input logic [31:0] d);
    req_wr_en = wr; req_rd_en = rd; req_strobe = s; req_addr = a; req_wdata = d;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0]  = '{2'b10, 4'hF, 32'h100,      32'hDEADBEEF, 2'b10, 4'hF, 32'h100,   4'b0000, 64'h0, 32'h0, 1'b0};
    tbl[1]  = '{2'b01, 4'hF, 32'h100,      32'h0,        2'b01, 4'h0, 32'h100,   4'b0000, 64'h0, 32'hDEADBEEF, 1'b0};
    tbl[2]  = '{2'b01, 4'hF, 32'h103,      32'h0,        2'b01, 4'h0, 32'h100,   4'b0000, 64'h0, 32'hDEADBEEF, 1'b0};
    tbl[3]  = '{2'b10, 4'h3, 32'h101,      32'hBEEF,     2'b00, 4'h0, 32'h0,     4'b0000, 64'h0, 32'h0, 1'b1};
    tbl[4]  = '{2'b01, 4'hF, 32'h100,      32'h0,        2'b01, 4'h0, 32'h100,   4'b0000, 64'h0, 32'hDEADBEEF, 1'b0};
    tbl[5]  = '{2'b01, 4'hF, 32'h80004,    32'h0,        2'b00, 4'h0, 32'h0,     4'b0001, 64'h0000_0000_0008_0004, 32'hA0A1A2A3, 1'b0};
    tbl[6]  = '{2'b01, 4'hF, 32'h40000004, 32'h0,        2'b00, 4'h0, 32'h0,     4'b0010, 64'h4000_0004_0000_0000, 32'hB0B1B2B3, 1'b0};
    tbl[7]  = '{2'b10, 4'hF, 32'h80FFC,    32'h5,        2'b00, 4'h0, 32'h0,     4'b0100, 64'h0000_0000_0008_0FFC, 32'h0, 1'b0};
    tbl[8]  = '{2'b01, 4'hF, 32'h81000,    32'h0,        2'b00, 4'h0, 32'h0,     4'b0000, 64'h0, 32'h0, 1'b0};
    tbl[9]  = '{2'b10, 4'hF, 32'h47FFC,    32'hCAFEF00D, 2'b10, 4'hF, 32'h47FFC, 4'b0000, 64'h0, 32'h0, 1'b0};
    tbl[10] = '{2'b01, 4'hF, 32'h47FFF,    32'h0,        2'b01, 4'h0, 32'h47FFC, 4'b0000, 64'h0, 32'hCAFEF00D, 1'b0};
    tbl[11] = '{2'b01, 4'hF, 32'h48000,    32'h0,        2'b00, 4'h0, 32'h0,     4'b0000, 64'h0, 32'h0, 1'b0};
    tbl[12] = '{2'b11, 4'hF, 32'h200,      32'h12345678, 2'b10, 4'hF, 32'h200,   4'b0000, 64'h0, 32'h0, 1'b0};
    tbl[13] = '{2'b01, 4'hF, 32'h200,      32'h0,        2'b01, 4'h0, 32'h200,   4'b0000, 64'h0, 32'h12345678, 1'b0};
    tbl[14] = '{2'b10, 4'hF, 32'h102,      32'h55,       2'b00, 4'h0, 32'h0,     4'b0000, 64'h0, 32'h0, 1'b1};
    tbl[15] = '{2'b10, 4'h1, 32'h80001,    32'h77,       2'b00, 4'h0, 32'h0,     4'b0100, 64'h0000_0000_0008_0001, 32'h0, 1'b0};
    tbl[16] = '{2'b01, 4'hF, 32'h3FFFFFFC, 32'h0,        2'b00, 4'h0, 32'h0,     4'b0000, 64'h0, 32'h0, 1'b0};
    tbl[17] = '{2'b01, 4'hF, 32'h40000FFF, 32'h0,        2'b00, 4'h0, 32'h0,     4'b0010, 64'h4000_0FFF_0000_0000, 32'hB0B1B2B3, 1'b0};

    // Reset state
    tick(); tick();
    check("reset_rsp", 128'(rsp_rdata), 128'h0);
    check("reset_mis", 128'(misalign_o), 128'h0);
    check("reset_stall_en", 128'({stall_o, lmb_wr_en, lmb_rd_en, per_wr_en, per_rd_en}), 128'h0);
    rst = 1'b1;
    tick();

    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].op[1], tbl[i].op[0], tbl[i].strb, tbl[i].addr, tbl[i].wdata);
      #1;
      check($sformatf("vec%0d_comb", i),
            128'({lmb_wr_en, lmb_rd_en, lmb_strobe, lmb_addr, per_wr_en, per_rd_en, per_addr, stall_o}),
            128'({tbl[i].e_lmb, tbl[i].e_lstrb, tbl[i].e_laddr, tbl[i].e_per, tbl[i].e_paddr, 1'b0}));
      tick();
      idle();
      check($sformatf("vec%0d_rsp", i), 128'(rsp_rdata), 128'(tbl[i].e_rsp));
      check($sformatf("vec%0d_mis", i), 128'(misalign_o), 128'(tbl[i].e_mis));
    end

    // Partial byte store: read cycle with stall, then merged full-word write
    drive(1'b1, 1'b0, 4'hF, 32'h100, 32'h11223344);
    tick();
    drive(1'b1, 1'b0, 4'h1, 32'h102, 32'h000000AA);
    #1;
    check("sb_c0", 128'({stall_o, lmb_rd_en, lmb_wr_en, lmb_addr}), 128'({3'b110, 32'h100}));
    tick();
    check("sb_c1", 128'({stall_o, lmb_rd_en, lmb_wr_en, lmb_strobe, lmb_addr, lmb_wdata, per_wr_en}),
          128'({3'b001, 4'hF, 32'h100, 32'h11AA3344, 2'b00}));
    tick();
    drive(1'b0, 1'b1, 4'hF, 32'h100, 32'h0);
    tick();
    idle();
    check("sb_readback", 128'(rsp_rdata), 128'h11AA3344);

    // Aligned halfword into upper half
    drive(1'b1, 1'b0, 4'h3, 32'h102, 32'h0000BEEF);
    #1;
    check("sh_c0_stall", 128'({stall_o, lmb_rd_en}), 128'(2'b11));
    tick();
    check("sh_c1", 128'({stall_o, lmb_wr_en, lmb_wdata}), 128'({2'b01, 32'hBEEF3344}));
    tick();
    drive(1'b0, 1'b1, 4'hF, 32'h100, 32'h0);
    tick();
    idle();
    check("sh_readback", 128'(rsp_rdata), 128'hBEEF3344);

    // Reset asserted while the merge write is pending
    drive(1'b1, 1'b0, 4'h1, 32'h101, 32'h00000055);
    #1;
    check("rstm_c0_stall", 128'(stall_o), 128'h1);
    tick();
    rst = 1'b0;
    idle();
    #1;
    check("rstm_no_write", 128'({lmb_wr_en, lmb_rd_en, stall_o}), 128'h0);
    check("rstm_rsp", 128'(rsp_rdata), 128'h0);
    tick();
    rst = 1'b1;
    check("rstm_after_rsp", 128'({rsp_rdata, misalign_o}), 128'h0);
    drive(1'b0, 1'b1, 4'hF, 32'h100, 32'h0);
    #1;
    check("rstm_idle_rd", 128'({stall_o, lmb_rd_en, lmb_wr_en}), 128'(3'b010));
    tick();
    idle();
    check("rstm_mem_unchanged", 128'(rsp_rdata), 128'hBEEF3344);

`ifdef DMEM_BUS_ERR_EN
    drive(1'b0, 1'b1, 4'hF, 32'h70000, 32'h0);
    #1;
    check("berr_no_en", 128'({lmb_wr_en, lmb_rd_en, per_wr_en, per_rd_en}), 128'h0);
    tick();
    idle();
    check("berr_pulse", 128'({bus_err_o, rsp_rdata}), 128'({1'b1, 32'h0}));
    tick();
    check("berr_clear", 128'(bus_err_o), 128'h0);
`endif

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
